resp_handshake_monitor: RTL and testbench

Synthesisable, parametrised protocol monitor for the RESP request/grant handshake.
- Watches NUM_CH independent request/grant pairs with a per-channel state machine.
- Checks request → grant after a programmable latency window → request drop → grant drop.
- Reports each completion or violation as a registered pulse with an error code.
- Keeps aggregate saturating pass/error counters.
- Replaces testbench-only concurrent assertions wherever the check must run in emulation, in formal harnesses, or on silicon debug buses.

---
 rtl/resp_handshake_monitor.sv | 198 +++++++++++++++++++
 tb/tb_resp_handshake_monitor.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/resp_handshake_monitor.sv
// RESP request/grant handshake monitor: one checker FSM per channel,
// registered pass/error pulses and saturating aggregate counters.
module resp_handshake_monitor #(
    parameter int NUM_CH  = 4,
    parameter int MIN_LAT = 3,
    parameter int MAX_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     request,
    input  logic [NUM_CH-1:0]     grant,
    input  logic                  clr_cnt,
    output logic [NUM_CH-1:0]     pass_pulse,
    output logic [NUM_CH-1:0]     err_pulse,
    output logic [3*NUM_CH-1:0]   err_code,
    output logic [CNT_W-1:0]      pass_cnt,
    output logic [CNT_W-1:0]      err_cnt,
    output logic                  err_any
);

    localparam int LAT_W = $clog2(MAX_LAT + 1);
    localparam int POP_W = $clog2(NUM_CH + 1);
    localparam int SUM_W = CNT_W + POP_W;

    localparam logic [LAT_W-1:0] MIN_L = LAT_W'(MIN_LAT);
    localparam logic [LAT_W-1:0] MAX_L = LAT_W'(MAX_LAT);
    localparam logic [LAT_W-1:0] ONE_L = LAT_W'(1);

    if (MIN_LAT < 1 || MAX_LAT < MIN_LAT) begin : g_param_check
        $error("resp_handshake_monitor: need 1 <= MIN_LAT <= MAX_LAT");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_GNT,
        ST_WAIT_REQ_LOW,
        ST_WAIT_GNT_LOW,
        ST_RESYNC
    } state_e;

    state_e           state_q [NUM_CH];
    state_e           state_d [NUM_CH];
    logic [LAT_W-1:0] lat_q   [NUM_CH];
    logic [LAT_W-1:0] lat_d   [NUM_CH];

    logic [NUM_CH-1:0]   pass_q, pass_d;
    logic [NUM_CH-1:0]   err_q, err_d;
    logic [3*NUM_CH-1:0] code_q, code_d;
    logic [CNT_W-1:0]    pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic                err_any_q, err_any_d;

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0]  cnt,
        input logic [NUM_CH-1:0] vec
    );
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(cnt);
        for (int i = 0; i < NUM_CH; i++) begin
            sum = sum + SUM_W'(vec[i]);
        end
        if (sum > SUM_W'({CNT_W{1'b1}})) begin
            return {CNT_W{1'b1}};
        end
        return sum[CNT_W-1:0];
    endfunction

    always_comb begin
        pass_d = '0;
        err_d  = '0;
        code_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c] = state_q[c];
            lat_d[c]   = lat_q[c];
            unique case (state_q[c])
                ST_IDLE: begin
                    if (grant[c]) begin
                        err_d[c]          = 1'b1;
                        code_d[3*c +: 3]  = 3'd1;
                        state_d[c]        = ST_RESYNC;
                    end else if (request[c]) begin
                        state_d[c] = ST_WAIT_GNT;
                        lat_d[c]   = ONE_L;
                    end
                end
                ST_WAIT_GNT: begin
                    if (grant[c] && lat_q[c] < MIN_L) begin
                        err_d[c]          = 1'b1;
                        code_d[3*c +: 3]  = 3'd2;
                        state_d[c]        = ST_RESYNC;
                        lat_d[c]          = '0;
                    end else if (grant[c]) begin
                        state_d[c] = ST_WAIT_REQ_LOW;
                        lat_d[c]   = '0;
                    end else if (!request[c]) begin
                        err_d[c]          = 1'b1;
                        code_d[3*c +: 3]  = 3'd3;
                        state_d[c]        = ST_RESYNC;
                        lat_d[c]          = '0;
                    end else if (lat_q[c] == MAX_L) begin
                        err_d[c]          = 1'b1;
                        code_d[3*c +: 3]  = 3'd4;
                        state_d[c]        = ST_RESYNC;
                        lat_d[c]          = '0;
                    end else begin
                        lat_d[c] = lat_q[c] + ONE_L;
                    end
                end
                ST_WAIT_REQ_LOW: begin
                    if (request[c]) begin
                        err_d[c]          = 1'b1;
                        code_d[3*c +: 3]  = 3'd5;
                        state_d[c]        = ST_RESYNC;
                    end else if (!grant[c]) begin
                        err_d[c]          = 1'b1;
                        code_d[3*c +: 3]  = 3'd6;
                        state_d[c]        = ST_RESYNC;
                    end else begin
                        state_d[c] = ST_WAIT_GNT_LOW;
                    end
                end
                ST_WAIT_GNT_LOW: begin
                    if (grant[c]) begin
                        err_d[c]          = 1'b1;
                        code_d[3*c +: 3]  = 3'd7;
                        state_d[c]        = ST_RESYNC;
                    end else begin
                        pass_d[c] = 1'b1;
                        // A request on the grant-drop sample starts the next transfer
                        if (request[c]) begin
                            state_d[c] = ST_WAIT_GNT;
                            lat_d[c]   = ONE_L;
                        end else begin
                            state_d[c] = ST_IDLE;
                        end
                    end
                end
                ST_RESYNC: begin
                    if (!request[c] && !grant[c]) begin
                        state_d[c] = ST_IDLE;
                    end
                end
                default: begin
                    state_d[c] = ST_IDLE;
                    lat_d[c]   = '0;
                end
            endcase
        end
    end

    // Counters follow the registered pulses, so they lag them by one cycle
    always_comb begin
        if (clr_cnt) begin
            pass_cnt_d = '0;
            err_cnt_d  = '0;
            err_any_d  = 1'b0;
        end else begin
            pass_cnt_d = sat_add(pass_cnt_q, pass_q);
            err_cnt_d  = sat_add(err_cnt_q, err_q);
            err_any_d  = err_any_q | (|err_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= ST_IDLE;
                lat_q[c]   <= '0;
            end
            pass_q     <= '0;
            err_q      <= '0;
            code_q     <= '0;
            pass_cnt_q <= '0;
            err_cnt_q  <= '0;
            err_any_q  <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= state_d[c];
                lat_q[c]   <= lat_d[c];
            end
            pass_q     <= pass_d;
            err_q      <= err_d;
            code_q     <= code_d;
            pass_cnt_q <= pass_cnt_d;
            err_cnt_q  <= err_cnt_d;
            err_any_q  <= err_any_d;
        end
    end

    assign pass_pulse = pass_q;
    assign err_pulse  = err_q;
    assign err_code   = code_q;
    assign pass_cnt   = pass_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign err_any    = err_any_q;

endmodule

// File: tb/tb_resp_handshake_monitor.sv
// Bench for resp_handshake_monitor: two instances (window 2..5 / wide
// counters, fixed 3 / 2-bit counters) checked against a timestamp model.
module tb_resp_handshake_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr_cnt = 1'b0;
    logic [3:0]  request = '0;
    logic [3:0]  grant = '0;

    logic [3:0]  a_pass, a_err, b_pass, b_err;
    logic [11:0] a_code, b_code;
    logic [15:0] a_pcnt, a_ecnt;
    logic [1:0]  b_pcnt, b_ecnt;
    logic        a_any, b_any;

    int total = 0;
    int bad = 0;
    int tick = 0;

    resp_handshake_monitor #(
        .NUM_CH(4), .MIN_LAT(2), .MAX_LAT(5), .CNT_W(16)
    ) dut_a (
        .clk(clk), .rst(rst), .request(request), .grant(grant),
        .clr_cnt(clr_cnt), .pass_pulse(a_pass), .err_pulse(a_err),
        .err_code(a_code), .pass_cnt(a_pcnt), .err_cnt(a_ecnt),
        .err_any(a_any)
    );

    resp_handshake_monitor #(
        .NUM_CH(4), .MIN_LAT(3), .MAX_LAT(3), .CNT_W(2)
    ) dut_b (
        .clk(clk), .rst(rst), .request(request), .grant(grant),
        .clr_cnt(clr_cnt), .pass_pulse(b_pass), .err_pulse(b_err),
        .err_code(b_code), .pass_cnt(b_pcnt), .err_cnt(b_ecnt),
        .err_any(b_any)
    );

    always #5 clk = ~clk;

    // Reference: per channel, timestamp of the start sample and of the
    // grant sample; everything else follows from offsets to those times.
    int          minl [2] = '{2, 3};
    int          maxl [2] = '{5, 3};
    int          cmax [2] = '{65535, 3};
    int          m_start [2][4];
    int          m_gnt [2][4];
    bit          m_rs [2][4];
    logic [3:0]  e_pass [2];
    logic [3:0]  e_err [2];
    logic [11:0] e_code [2];
    int          e_pcnt [2];
    int          e_ecnt [2];
    logic        e_any [2];

    logic [1:0]  sq [4][$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [3:0] r, input logic [3:0] g,
                              input logic c, input logic rs);
        for (int d = 0; d < 2; d++) begin
            logic [3:0]  np;
            logic [3:0]  ne;
            logic [11:0] nc;
            np = '0;
            ne = '0;
            nc = '0;
            if (rs) begin
                for (int ch = 0; ch < 4; ch++) begin
                    m_start[d][ch] = -1;
                    m_gnt[d][ch] = -1;
                    m_rs[d][ch] = 1'b0;
                end
                e_pcnt[d] = 0;
                e_ecnt[d] = 0;
                e_any[d] = 1'b0;
            end else begin
                if (c) begin
                    e_pcnt[d] = 0;
                    e_ecnt[d] = 0;
                    e_any[d] = 1'b0;
                end else begin
                    e_pcnt[d] += $countones(e_pass[d]);
                    e_ecnt[d] += $countones(e_err[d]);
                    if (e_pcnt[d] > cmax[d]) e_pcnt[d] = cmax[d];
                    if (e_ecnt[d] > cmax[d]) e_ecnt[d] = cmax[d];
                    e_any[d] = e_any[d] | (|e_err[d]);
                end
                for (int ch = 0; ch < 4; ch++) begin
                    bit ri;
                    bit gi;
                    int ev;
                    int k;
                    ri = r[ch];
                    gi = g[ch];
                    ev = 0;
                    if (m_rs[d][ch]) begin
                        if (!ri && !gi) m_rs[d][ch] = 1'b0;
                    end else if (m_start[d][ch] < 0) begin
                        if (gi) ev = 1;
                        else if (ri) m_start[d][ch] = tick;
                    end else if (m_gnt[d][ch] < 0) begin
                        k = tick - m_start[d][ch];
                        if (gi) begin
                            if (k < minl[d]) ev = 2;
                            else m_gnt[d][ch] = tick;
                        end else if (!ri) ev = 3;
                        else if (k == maxl[d]) ev = 4;
                    end else if (tick - m_gnt[d][ch] == 1) begin
                        if (ri) ev = 5;
                        else if (!gi) ev = 6;
                    end else begin
                        if (gi) ev = 7;
                        else begin
                            ev = -1;
                            m_start[d][ch] = ri ? tick : -1;
                            m_gnt[d][ch] = -1;
                        end
                    end
                    if (ev > 0) begin
                        m_rs[d][ch] = 1'b1;
                        m_start[d][ch] = -1;
                        m_gnt[d][ch] = -1;
                        ne[ch] = 1'b1;
                        nc[3*ch +: 3] = 3'(ev);
                    end
                    if (ev == -1) np[ch] = 1'b1;
                end
            end
            e_pass[d] = np;
            e_err[d] = ne;
            e_code[d] = nc;
        end
        tick++;
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] g,
                        input logic c, input logic rs);
        request = r;
        grant = g;
        clr_cnt = c;
        rst = rs;
        @(posedge clk);
        model_edge(r, g, c, rs);
        #1;
        chk("a_pass", 32'(a_pass), 32'(e_pass[0]));
        chk("a_err", 32'(a_err), 32'(e_err[0]));
        chk("a_code", 32'(a_code), 32'(e_code[0]));
        chk("a_pcnt", 32'(a_pcnt), 32'(e_pcnt[0]));
        chk("a_ecnt", 32'(a_ecnt), 32'(e_ecnt[0]));
        chk("a_any", 32'(a_any), 32'(e_any[0]));
        chk("b_pass", 32'(b_pass), 32'(e_pass[1]));
        chk("b_err", 32'(b_err), 32'(e_err[1]));
        chk("b_code", 32'(b_code), 32'(e_code[1]));
        chk("b_pcnt", 32'(b_pcnt), 32'(e_pcnt[1]));
        chk("b_ecnt", 32'(b_ecnt), 32'(e_ecnt[1]));
        chk("b_any", 32'(b_any), 32'(e_any[1]));
    endtask

    task automatic legal(input logic [3:0] m, input int lat);
        for (int i = 0; i < lat; i++) step(m, 4'h0, 1'b0, 1'b0);
        step(m, m, 1'b0, 1'b0);
        step(4'h0, m, 1'b0, 1'b0);
        step(4'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic gen(input int ch);
        logic [1:0] tx[$];
        int gap;
        int lat;
        int idx;
        gap = $urandom_range(0, 2);
        lat = $urandom_range(1, 6);
        for (int i = 0; i < gap; i++) tx.push_back(2'b00);
        for (int i = 0; i < lat; i++) tx.push_back(2'b10);
        tx.push_back(2'b11);
        tx.push_back(2'b01);
        if ($urandom_range(0, 3) != 0) tx.push_back(2'b00);
        if ($urandom_range(0, 5) == 0) begin
            idx = $urandom_range(0, tx.size() - 1);
            tx[idx] = tx[idx] ^ 2'($urandom_range(1, 3));
        end
        foreach (tx[i]) sq[ch].push_back(tx[i]);
    endtask

    initial begin
        logic [3:0] r;
        logic [3:0] g;
        logic [1:0] e;

        step(4'h0, 4'h0, 1'b0, 1'b1);
        step(4'h0, 4'h0, 1'b0, 1'b1);
        step(4'h0, 4'h0, 1'b0, 1'b0);

        legal(4'b0001, 3);
        chk("tp_legal_pass", 32'(b_pass), 32'h1);
        step(4'h0, 4'h0, 1'b0, 1'b0);
        chk("tp_legal_cnt", 32'(b_pcnt), 32'h1);

        step(4'b0010, 4'h0, 1'b0, 1'b0);
        step(4'b0010, 4'b0010, 1'b0, 1'b0);
        chk("tp_early_code", 32'(b_code[5:3]), 32'h2);
        step(4'b0010, 4'b0010, 1'b0, 1'b0);
        step(4'b0010, 4'b0010, 1'b0, 1'b0);
        step(4'h0, 4'b0010, 1'b0, 1'b0);
        step(4'h0, 4'h0, 1'b0, 1'b0);
        legal(4'b0010, 3);

        repeat (3) step(4'b0001, 4'h0, 1'b0, 1'b0);
        step(4'b0001, 4'b0001, 1'b0, 1'b0);
        step(4'b0001, 4'b0001, 1'b0, 1'b0);
        chk("tp_req_hold", 32'(b_code[2:0]), 32'h5);
        step(4'h0, 4'h0, 1'b0, 1'b0);

        repeat (3) step(4'b0001, 4'h0, 1'b0, 1'b0);
        step(4'b0001, 4'b0001, 1'b0, 1'b0);
        step(4'h0, 4'b0001, 1'b0, 1'b0);
        step(4'h0, 4'b0001, 1'b0, 1'b0);
        chk("tp_gnt_hold", 32'(a_code[2:0]), 32'h7);
        step(4'h0, 4'h0, 1'b0, 1'b0);

        step(4'h0, 4'b0001, 1'b0, 1'b0);
        chk("tp_spurious", 32'(a_code[2:0]), 32'h1);
        step(4'h0, 4'h0, 1'b0, 1'b0);

        legal(4'b1000, 2);
        legal(4'b1000, 5);
        repeat (6) step(4'b1000, 4'h0, 1'b0, 1'b0);
        chk("tp_timeout", 32'(a_code[11:9]), 32'h4);
        step(4'h0, 4'h0, 1'b0, 1'b0);

        legal(4'b1111, 3);
        step(4'h0, 4'h0, 1'b0, 1'b0);
        chk("tp_sat", 32'(b_pcnt), 32'h3);
        legal(4'b1111, 3);
        step(4'h0, 4'h0, 1'b1, 1'b0);
        chk("tp_clr", 32'(a_pcnt), 32'h0);

        step(4'b0100, 4'h0, 1'b0, 1'b0);
        step(4'b0100, 4'h0, 1'b0, 1'b0);
        step(4'h0, 4'h0, 1'b0, 1'b1);
        step(4'h0, 4'h0, 1'b0, 1'b0);
        legal(4'b0100, 3);

        repeat (3) step(4'b0001, 4'h0, 1'b0, 1'b0);
        step(4'b0001, 4'b0001, 1'b0, 1'b0);
        step(4'h0, 4'b0001, 1'b0, 1'b0);
        step(4'b0001, 4'h0, 1'b0, 1'b0);
        repeat (2) step(4'b0001, 4'h0, 1'b0, 1'b0);
        step(4'b0001, 4'b0001, 1'b0, 1'b0);
        step(4'h0, 4'b0001, 1'b0, 1'b0);
        step(4'h0, 4'h0, 1'b0, 1'b0);
        step(4'h0, 4'h0, 1'b0, 1'b0);

        for (int n = 0; n < 2500; n++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (sq[ch].size() == 0) gen(ch);
                e = sq[ch].pop_front();
                r[ch] = e[1];
                g[ch] = e[0];
            end
            step(r, g, ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 299) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
